// File: rtl/issue_ctrl.sv
// Single-entry issue buffer with RAW/WAW/writeback-port hazard checks.
// Optional stall counter enabled by defining ISSUE_STALL_CNT_EN.
module issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_regA,
  input  logic [4:0]  in_regB,
  input  logic [4:0]  in_regC,
  input  logic        in_useB,
  input  logic [1:0]  in_unit,
  input  logic [0:31] pendente,
  input  logic        flush,
  output logic        iss_valid,
  output logic [4:0]  iss_regC,
  output logic [1:0]  iss_unit,
  output logic        iss_we,
  output logic [15:0] stall_cycles
);

  localparam logic [1:0] UnitAlu   = 2'b00;
  localparam logic [1:0] UnitLoad  = 2'b01;
  localparam logic [1:0] UnitStore = 2'b10;
  localparam logic [1:0] UnitMul   = 2'b11;

  typedef enum logic [1:0] {StEmpty, StFull, StStall} state_e;

  state_e     state_q, state_d;
  logic [4:0] rega_q, regb_q, regc_q;
  logic       useb_q;
  logic [1:0] unit_q;
  logic [4:0] res_q, res_d;

  logic       buf_valid, is_store, raw, waw, struct_haz, hazard, issue_now, accept;
  logic [4:0] wb_onehot;

  assign buf_valid = (state_q != StEmpty);
  assign is_store  = (unit_q == UnitStore);

  // Register 0 is hardwired, so it never blocks on the scoreboard.
  assign raw = ((rega_q != 5'd0) && pendente[rega_q]) ||
               (useb_q && (regb_q != 5'd0) && pendente[regb_q]) ||
               (is_store && (regc_q != 5'd0) && pendente[regc_q]);
  assign waw = !is_store && (regc_q != 5'd0) && pendente[regc_q];

  // res[k] marks the writeback port taken k cycles from now.
  always_comb begin
    struct_haz = 1'b0;
    wb_onehot  = 5'b00000;
    unique case (unit_q)
      UnitAlu:   begin struct_haz = res_q[2]; wb_onehot = 5'b00010; end
      UnitLoad:  begin struct_haz = res_q[3]; wb_onehot = 5'b00100; end
      UnitStore: begin struct_haz = 1'b0;     wb_onehot = 5'b00000; end
      UnitMul:   begin struct_haz = 1'b0;     wb_onehot = 5'b10000; end
      default:   begin struct_haz = 1'b0;     wb_onehot = 5'b00000; end
    endcase
  end

  assign hazard    = raw || waw || struct_haz;
  assign issue_now = rst && buf_valid && !flush && !hazard;
  assign in_ready  = rst && (!buf_valid || issue_now) && !flush;
  assign accept    = in_valid && in_ready;

  assign iss_valid = issue_now;
  assign iss_regC  = (rst && buf_valid) ? regc_q : 5'd0;
  assign iss_unit  = (rst && buf_valid) ? unit_q : 2'd0;
  assign iss_we    = rst && buf_valid && !is_store;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else if (buf_valid) begin
      if (issue_now) state_d = accept ? StFull : StEmpty;
      else           state_d = StStall;
    end else if (accept) begin
      state_d = StFull;
    end
  end

  assign res_d = {1'b0, res_q[4:1]} | (issue_now ? wb_onehot : 5'b00000);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StEmpty;
      res_q   <= 5'd0;
      rega_q  <= 5'd0;
      regb_q  <= 5'd0;
      regc_q  <= 5'd0;
      useb_q  <= 1'b0;
      unit_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      if (accept) begin
        rega_q <= in_regA;
        regb_q <= in_regB;
        regc_q <= in_regC;
        useb_q <= in_useB;
        unit_q <= in_unit;
      end
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= 16'd0;
    end else if (buf_valid && !issue_now && !flush && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Randomized + directed bench for issue_ctrl against a writeback-slot model.
module tb_issue_ctrl;

  localparam logic [1:0] UAlu = 2'b00, ULoad = 2'b01, UStore = 2'b10, UMul = 2'b11;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_useB, flush;
  logic [4:0]  in_regA, in_regB, in_regC;
  logic [1:0]  in_unit;
  logic [0:31] pendente;
  logic        iss_valid, iss_we;
  logic [4:0]  iss_regC;
  logic [1:0]  iss_unit;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  issue_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_regA(in_regA), .in_regB(in_regB), .in_regC(in_regC), .in_useB(in_useB),
    .in_unit(in_unit), .pendente(pendente), .flush(flush), .iss_valid(iss_valid),
    .iss_regC(iss_regC), .iss_unit(iss_unit), .iss_we(iss_we), .stall_cycles(stall_cycles)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;

  // Model: buffer contents plus the absolute cycles at which writebacks land.
  bit         m_bv = 1'b0;
  logic [4:0] m_a, m_b, m_c;
  bit         m_ub;
  logic [1:0] m_u;
  int         m_stall = 0;
  int         wb_q[$];

  logic        s_rdy, s_iv, s_we;
  logic [4:0]  s_rc;
  logic [1:0]  s_u;
  logic [15:0] s_st;

  function automatic int lat_of(input logic [1:0] u);
    case (u)
      ULoad:   return 3;
      UMul:    return 5;
      default: return 2;
    endcase
  endfunction

  function automatic bit hit(input logic [4:0] r, input logic [0:31] p);
    return (r != 5'd0) && (p[r] == 1'b1);
  endfunction

  function automatic logic [0:31] pbit(input int r);
    logic [0:31] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit iv, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c, input bit ub, input logic [1:0] u,
                      input logic [0:31] p, input bit fl);
    bit is_st, raw, waw, strc, e_issue, e_rdy;
    int l;
    rst = r; in_valid = iv; in_regA = a; in_regB = b; in_regC = c;
    in_useB = ub; in_unit = u; pendente = p; flush = fl;
    @(negedge clk);
    is_st = (m_u == UStore);
    l     = lat_of(m_u);
    raw   = hit(m_a, p) || (m_ub && hit(m_b, p)) || (is_st && hit(m_c, p));
    waw   = !is_st && hit(m_c, p);
    strc  = 1'b0;
    if (!is_st && l <= 4)
      foreach (wb_q[i]) if (wb_q[i] == cyc + l) strc = 1'b1;
    e_issue = r && m_bv && !fl && !(raw || waw || strc);
    e_rdy   = r && (!m_bv || e_issue) && !fl;
    chk("in_ready", in_ready, e_rdy);
    chk("iss_valid", iss_valid, e_issue);
    chk("iss_regC", iss_regC, (r && m_bv) ? m_c : 5'd0);
    chk("iss_unit", iss_unit, (r && m_bv) ? m_u : 2'd0);
    if (r && m_bv) chk("iss_we", iss_we, !is_st);
`ifdef ISSUE_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall);
`else
    chk("stall_cycles", stall_cycles, 0);
`endif
    s_rdy = in_ready; s_iv = iss_valid; s_we = iss_we; s_rc = iss_regC; s_u = iss_unit;
    s_st = stall_cycles;
    if (!r) begin
      m_bv = 1'b0; m_stall = 0; wb_q.delete();
    end else begin
      if (e_issue && !is_st) wb_q.push_back(cyc + l);
      if (m_bv && !e_issue && !fl && m_stall < 65535) m_stall++;
      if (fl) m_bv = 1'b0;
      else if (iv && e_rdy) begin
        m_bv = 1'b1; m_a = a; m_b = b; m_c = c; m_ub = ub; m_u = u;
      end else if (e_issue) m_bv = 1'b0;
    end
    cyc++;
    for (int i = wb_q.size() - 1; i >= 0; i--) if (wb_q[i] < cyc) wb_q.delete(i);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0; in_valid = 0; in_regA = 0; in_regB = 0; in_regC = 0;
    in_useB = 0; in_unit = 0; pendente = '0; flush = 0;
    @(posedge clk);
    #1;
    // Reset cycles: outputs held low even with a valid input.
    step(0, 1, 1, 2, 3, 1, UAlu, '0, 0);
    chk("rst_ready", s_rdy, 0); chk("rst_valid", s_iv, 0);
    step(0, 0, 0, 0, 0, 0, UAlu, '0, 0);

    // ALU r1 <- r2,r3 issues the cycle after acceptance.
    step(1, 1, 2, 3, 1, 1, UAlu, '0, 0);
    chk("alu_accept_ready", s_rdy, 1); chk("alu_not_same_cycle", s_iv, 0);
    step(1, 0, 0, 0, 0, 0, UAlu, '0, 0);
    chk("alu_issue", s_iv, 1); chk("alu_regC", s_rc, 1);
    chk("alu_unit", s_u, 0); chk("alu_we", s_we, 1);

    // RAW on r5 for three cycles; buffer must hold despite new inputs.
    step(1, 1, 5, 0, 8, 0, UAlu, pbit(5), 0);
    chk("raw_accept", s_rdy, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 9, 9, 12, 1, UMul, pbit(5), 0);
      chk("raw_stall_valid", s_iv, 0); chk("raw_stall_ready", s_rdy, 0);
      chk("raw_hold_regC", s_rc, 8);
    end
    step(1, 0, 0, 0, 0, 0, UAlu, '0, 0);
    chk("raw_release", s_iv, 1); chk("raw_release_regC", s_rc, 8);
`ifdef ISSUE_STALL_CNT_EN
    chk("stall_count_3", s_st, 3);
`else
    chk("stall_count_off", s_st, 0);
`endif

    // r0 is never a hazard.
    step(1, 1, 0, 0, 9, 0, UAlu, pbit(0), 0);
    step(1, 0, 0, 0, 0, 0, UAlu, pbit(0), 0);
    chk("r0_issue", s_iv, 1); chk("r0_regC", s_rc, 9);

    // LOAD then ALU collide on the writeback port; MULs stream freely.
    step(1, 1, 1, 0, 4, 0, ULoad, '0, 0);
    step(1, 1, 2, 0, 6, 0, UAlu, '0, 0);
    chk("load_issue", s_iv, 1); chk("load_regC", s_rc, 4);
    step(1, 0, 0, 0, 0, 0, UAlu, '0, 0);
    chk("alu_after_load_blocked", s_iv, 0); chk("alu_after_load_regC", s_rc, 6);
    step(1, 1, 1, 0, 10, 0, UMul, '0, 0);
    chk("alu_after_load_issue", s_iv, 1);
    step(1, 1, 1, 0, 11, 0, UMul, '0, 0);
    chk("mul1_issue", s_iv, 1); chk("mul1_regC", s_rc, 10);
    step(1, 0, 0, 0, 0, 0, UAlu, '0, 0);
    chk("mul2_issue", s_iv, 1); chk("mul2_regC", s_rc, 11);

    // STORE waits on its data register and never writes.
    step(1, 1, 1, 2, 7, 0, UStore, pbit(7), 0);
    step(1, 0, 0, 0, 0, 0, UAlu, pbit(7), 0);
    chk("store_stall", s_iv, 0);
    step(1, 0, 0, 0, 0, 0, UAlu, '0, 0);
    chk("store_issue", s_iv, 1); chk("store_we", s_we, 0); chk("store_unit", s_u, 2);

    // Flush during stall, then reset during stall.
    step(1, 1, 5, 0, 3, 0, UAlu, pbit(5), 0);
    step(1, 0, 0, 0, 0, 0, UAlu, pbit(5), 0);
    chk("pre_flush_stall", s_iv, 0);
    step(1, 1, 1, 1, 1, 0, UAlu, pbit(5), 1);
    chk("flush_valid", s_iv, 0); chk("flush_ready", s_rdy, 0);
    step(1, 0, 0, 0, 0, 0, UAlu, pbit(5), 0);
    chk("after_flush_empty", s_rdy, 1); chk("after_flush_valid", s_iv, 0);
    step(1, 1, 5, 0, 3, 0, UAlu, pbit(5), 0);
    step(1, 0, 0, 0, 0, 0, UAlu, pbit(5), 0);
    step(0, 0, 0, 0, 0, 0, UAlu, '0, 0);
    chk("rst_stall_valid", s_iv, 0); chk("rst_stall_ready", s_rdy, 0);
    chk("rst_stall_regC", s_rc, 0); chk("rst_stall_unit", s_u, 0);
    chk("rst_stall_we", s_we, 0);
    step(1, 0, 0, 0, 0, 0, UAlu, '0, 0);
    chk("rst_discard", s_iv, 0); chk("rst_then_empty", s_rdy, 1);

    // Random traffic over a small register set to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pr;
      pr = $urandom & $urandom & $urandom;
      step($urandom_range(99) != 0, $urandom_range(3) != 0,
           5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
           1'($urandom_range(1)), 2'($urandom_range(3)), pr, $urandom_range(15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-low; clock clk.
REQ-003 in_valid  in  1  decode presents an instruction.
REQ-004 in_ready  out  1  issue stage accepts instruction this cycle.
REQ-005 in_regA, in_regB, in_regC  in  5 each  source A, source B, destination (store: data source).
REQ-006 in_useB  in  1  instruction reads regB.
REQ-007 in_unit  in  2  functional unit: 00 ALU, 01 LOAD, 10 STORE, 11 MUL.
REQ-008 pendente  in  32 [0:31]  scoreboard pending column, bit r = register r pending.
REQ-009 flush  in  1  discard buffered instruction.
REQ-010 iss_valid  out  1  instruction issues this cycle (scoreboard captures at next edge).
REQ-011 iss_regC  out  5; iss_unit  out  2; iss_we  out  1  issued destination, unit, writes-register flag.
REQ-012 stall_cycles  out  16  saturating stall counter (see Configuration).

Function
REQ-013 One-entry instruction buffer; in_ready SHALL be (!buf_valid || issue_now) && !flush.
REQ-014 Accept on in_valid && in_ready at edge N; earliest iss_valid in cycle N+1; sustained throughput one instruction per cycle when hazard-free.
REQ-015 Unit latencies SHALL be ALU 2, LOAD 3, STORE 2, MUL 5 cycles.
REQ-016 RAW hazard: pendente[regA], or in_useB && pendente[regB], or (STORE && pendente[regC]).
REQ-017 WAW hazard: non-STORE && pendente[regC].
REQ-018 Register 0 SHALL never cause a RAW or WAW hazard.
REQ-019 Writeback reservation vector res[4:0]; structural hazard for non-STORE latency L when L<=4 && res[L]; MUL never structurally conflicts.
REQ-020 Each edge: res <= {1'b0, res[4:1]} | (issue_now && iss_we ? onehot(L-1) : 0).
REQ-021 issue_now = buf_valid && !flush && no RAW/WAW/structural hazard; iss_valid = issue_now (combinational from registered state and inputs).
REQ-022 iss_we SHALL be 0 for STORE, 1 otherwise; iss_regC/iss_unit SHALL reflect buffer contents whenever buf_valid, else 0.
REQ-023 FSM states EMPTY, FULL, STALL: EMPTY->FULL on accept; FULL->STALL when hazard; FULL/STALL->FULL on issue with simultaneous accept; FULL/STALL->EMPTY on issue without accept; STALL holds while hazard.
REQ-024 flush SHALL clear buffer (->EMPTY) and block accept and issue that cycle; res keeps shifting unaffected.
REQ-025 Buffered instruction SHALL remain unchanged while stalled regardless of in_* inputs.

Reset
REQ-026 rst==0 at edge: state EMPTY, buf_valid 0, res 0, stall_cycles 0.
REQ-027 During reset cycle outputs: in_ready 0, iss_valid 0, iss_regC 0, iss_unit 0, iss_we 0.
REQ-028 Reset mid-stall SHALL discard the buffered instruction without issuing it.

Configuration
REQ-029 Macro ISSUE_STALL_CNT_EN defined: stall_cycles increments each cycle buf_valid && !issue_now && !flush, saturates at 16'hFFFF, never wraps.
REQ-030 ISSUE_STALL_CNT_EN undefined: stall_cycles SHALL be constant 0; port remains present.

Verification
REQ-031 ALU r1<-r2,r3 with pendente=0 accepted at edge N -> iss_valid=1 cycle N+1, iss_regC=1, iss_unit=00, iss_we=1.
REQ-032 pendente[5]=1, ALU reads regA=5 -> iss_valid=0, in_ready=0 until pendente[5] cleared, then issue next cycle; stall_cycles equals stalled cycles (macro on), 0 (macro off).
REQ-033 regA=0 with pendente[0]=1 -> no stall, issue cycle N+1.
REQ-034 LOAD r4 issued cycle K then ALU r6 back-to-back -> ALU issue in cycle K+1 blocked (res[2] set), issues cycle K+2; MUL back-to-back never blocked.
REQ-035 STORE regC=7, pendente[7]=1 -> stall; pendente[7]=0 -> issue with iss_we=0, res unchanged.
REQ-036 flush asserted during STALL -> iss_valid 0, state EMPTY next cycle; rst=0 mid-stall -> all outputs 0, no issue.
